// File: rtl/nmr_rx_pkg.sv
// Shared widths, FSM state type and packed-lane helper for the NMR receive demodulator.
package nmr_rx_pkg;
  localparam int LANES  = 8;
  localparam int SAMP_W = 16;
  localparam int PROD_W = 2 * SAMP_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic signed [SAMP_W-1:0] lane(input logic [LANES*SAMP_W-1:0] w,
                                                    input int i);
    return w[i*SAMP_W +: SAMP_W];
  endfunction
endpackage

// File: rtl/mix_sum8.sv
// Two-stage mixer: per-lane registered multiply (S1), registered 8-way adder tree (S2).
module mix_sum8
  import nmr_rx_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_vld,
  input  logic [LANES*SAMP_W-1:0]        a,
  input  logic [LANES*SAMP_W-1:0]        b,
  output logic signed [SUM_W-1:0]        sum,
  output logic                           sum_vld
);
  logic [LANES-1:0][PROD_W-1:0] prod_d, prod_q;
  logic signed [SUM_W-1:0]      sum_d, sum_q;
  logic [2:1]                   vld_pipe_d, vld_pipe_q;

  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i] = lane(a, i) * lane(b, i);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++)
      sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
  end

  // flush kills words in flight so an aborted block leaves nothing behind
  always_comb begin
    vld_pipe_d[1] = in_vld & ~flush;
    vld_pipe_d[2] = vld_pipe_q[1] & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      sum_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      prod_q     <= prod_d;
      sum_q      <= sum_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign sum     = sum_q;
  assign sum_vld = vld_pipe_q[2];
endmodule

// File: rtl/nmr_iq_demod.sv
// I/Q demodulator: mixes ADC words with DDS LO and boxcar-integrates into I/Q blocks.
module nmr_iq_demod
  import nmr_rx_pkg::*;
#(
  parameter int ACC_W = 52,
  parameter int LEN_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [LEN_W-1:0]          dec_len,
  input  logic [LANES*SAMP_W-1:0]   adc_data,
  input  logic                      adc_val,
  input  logic [LANES*SAMP_W-1:0]   lo_sin,
  input  logic [LANES*SAMP_W-1:0]   lo_cos,
  input  logic                      lo_val,
  output logic signed [ACC_W-1:0]   i_out,
  output logic signed [ACC_W-1:0]   q_out,
  output logic                      iq_val,
  output logic [31:0]               blk_cnt,
  output logic                      busy
);
  logic                    accept, vld_i, vld_q, s2_vld;
  logic signed [SUM_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] word_i, word_q;
  logic [LEN_W-1:0]        len_eff;
  logic [LEN_W:0]          cnt_nxt;

  state_e                  state_d, state_q;
  logic [LEN_W-1:0]        len_d, len_q, cnt_d, cnt_q;
  logic signed [ACC_W-1:0] iacc_d, iacc_q, qacc_d, qacc_q;
  logic signed [ACC_W-1:0] i_out_d, i_out_q, q_out_d, q_out_q;
  logic                    iq_val_d, iq_val_q;
  logic [31:0]             blk_cnt_d, blk_cnt_q;

  assign accept = en & adc_val & lo_val;

  mix_sum8 u_mix_i (.clk(clk), .rst_n(rst_n), .flush(~en), .in_vld(accept),
                    .a(adc_data), .b(lo_cos), .sum(sum_i), .sum_vld(vld_i));
  mix_sum8 u_mix_q (.clk(clk), .rst_n(rst_n), .flush(~en), .in_vld(accept),
                    .a(adc_data), .b(lo_sin), .sum(sum_q), .sum_vld(vld_q));

  assign s2_vld  = vld_i & vld_q;
  assign word_i  = {{(ACC_W-SUM_W){sum_i[SUM_W-1]}}, sum_i};
  assign word_q  = {{(ACC_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
  assign len_eff = (dec_len == '0) ? LEN_W'(1) : dec_len;
  assign cnt_nxt = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    iacc_d    = iacc_q;
    qacc_d    = qacc_q;
    i_out_d   = i_out_q;
    q_out_d   = q_out_q;
    iq_val_d  = 1'b0;
    blk_cnt_d = blk_cnt_q;
    case (state_q)
      IDLE: if (en) begin
        state_d = RUN;
        len_d   = len_eff;
        cnt_d   = '0;
        iacc_d  = '0;
        qacc_d  = '0;
      end
      RUN: if (!en) begin
        state_d = IDLE;
        cnt_d   = '0;
        iacc_d  = '0;
        qacc_d  = '0;
      end else if (s2_vld) begin
        // closing word goes straight to the output so the next block starts gap-free
        if (cnt_nxt == {1'b0, len_q}) begin
          i_out_d   = iacc_q + word_i;
          q_out_d   = qacc_q + word_q;
          iq_val_d  = 1'b1;
          blk_cnt_d = blk_cnt_q + 32'd1;
          iacc_d    = '0;
          qacc_d    = '0;
          cnt_d     = '0;
          len_d     = len_eff;
        end else begin
          iacc_d = iacc_q + word_i;
          qacc_d = qacc_q + word_q;
          cnt_d  = cnt_nxt[LEN_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      iacc_q    <= '0;
      qacc_q    <= '0;
      i_out_q   <= '0;
      q_out_q   <= '0;
      iq_val_q  <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      iacc_q    <= iacc_d;
      qacc_q    <= qacc_d;
      i_out_q   <= i_out_d;
      q_out_q   <= q_out_d;
      iq_val_q  <= iq_val_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign i_out   = i_out_q;
  assign q_out   = q_out_q;
  assign iq_val  = iq_val_q;
  assign blk_cnt = blk_cnt_q;
  assign busy    = (state_q == RUN);
endmodule

// File: tb/tb_nmr_iq_demod.sv
// Directed bench for nmr_iq_demod: block sums, latency, bubbles, decimation 0/1, abort, reset.
module tb_nmr_iq_demod;
  logic               clk = 1'b0;
  logic               rst_n, en, adc_val, lo_val;
  logic [15:0]        dec_len;
  logic [127:0]       adc_data, lo_sin, lo_cos;
  logic signed [51:0] i_out, q_out;
  logic               iq_val, busy;
  logic [31:0]        blk_cnt;

  int     n_cmp = 0, n_bad = 0, cyc = 0, exp_blk = 0;
  longint last_i = 0, last_q = 0;

  nmr_iq_demod dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dec_len(dec_len),
    .adc_data(adc_data), .adc_val(adc_val), .lo_sin(lo_sin), .lo_cos(lo_cos),
    .lo_val(lo_val), .i_out(i_out), .q_out(q_out), .iq_val(iq_val),
    .blk_cnt(blk_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // lane i carries base + step*i for each stream
  task automatic set_lanes(input int ab, input int as, input int cb, input int cs,
                           input int sb, input int ss);
    for (int i = 0; i < 8; i++) begin
      adc_data[i*16 +: 16] = 16'(ab + as*i);
      lo_cos[i*16 +: 16]   = 16'(cb + cs*i);
      lo_sin[i*16 +: 16]   = 16'(sb + ss*i);
    end
  endtask

  function automatic longint dot(input int ab, input int as, input int bb, input int bs);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'(ab + as*i) * longint'(bb + bs*i);
    return s;
  endfunction

  task automatic go_idle;
    en = 1'b0; adc_val = 1'b0; lo_val = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; adc_val = 1'b0; lo_val = 1'b0; dec_len = 16'd4;
    set_lanes(0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    n_cmp++; if (i_out !== 52'sd0)   begin n_bad++; $display("FAIL reset_i got %0d want 0", i_out); end
    n_cmp++; if (q_out !== 52'sd0)   begin n_bad++; $display("FAIL reset_q got %0d want 0", q_out); end
    n_cmp++; if (iq_val !== 1'b0)    begin n_bad++; $display("FAIL reset_iqval got %b want 0", iq_val); end
    n_cmp++; if (blk_cnt !== 32'd0)  begin n_bad++; $display("FAIL reset_blk got %0d want 0", blk_cnt); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (2) tick;
  endtask

  // four words of adc=100, cos=1000: 4*8*100000 = 3,200,000
  task automatic test_basic;
    int c0, n;
    dec_len = 16'd4; en = 1'b1; set_lanes(100, 0, 1000, 0, 0, 0);
    c0 = cyc;
    for (int j = 0; j < 10; j++) begin
      adc_val = (j < 4); lo_val = (j < 4);
      tick; n = cyc - c0;
      n_cmp++; if (iq_val !== (n == 6)) begin n_bad++; $display("FAIL basic_iqval n=%0d got %b want %b", n, iq_val, n == 6); end
      if (n == 6) begin
        exp_blk++;
        n_cmp++; if (i_out !== 52'sd3200000) begin n_bad++; $display("FAIL basic_i got %0d want 3200000", i_out); end
        n_cmp++; if (q_out !== 52'sd0)       begin n_bad++; $display("FAIL basic_q got %0d want 0", q_out); end
        n_cmp++; if (blk_cnt !== 32'(exp_blk)) begin n_bad++; $display("FAIL basic_blk got %0d want %0d", blk_cnt, exp_blk); end
        n_cmp++; if (busy !== 1'b1)          begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
      end
    end
    last_i = 3200000; last_q = 0;
    go_idle;
  endtask

  task automatic test_bubbles;
    int c0, n;
    dec_len = 16'd4; en = 1'b1; set_lanes(100, 0, 1000, 0, 0, 0); lo_val = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 12; j++) begin
      adc_val = (j < 6) && (j != 2) && (j != 3);
      lo_val  = (j < 6);
      tick; n = cyc - c0;
      n_cmp++; if (iq_val !== (n == 8)) begin n_bad++; $display("FAIL bubble_iqval n=%0d got %b want %b", n, iq_val, n == 8); end
      if (n == 8) begin
        exp_blk++;
        n_cmp++; if (i_out !== 52'sd3200000) begin n_bad++; $display("FAIL bubble_i got %0d want 3200000", i_out); end
        n_cmp++; if (blk_cnt !== 32'(exp_blk)) begin n_bad++; $display("FAIL bubble_blk got %0d want %0d", blk_cnt, exp_blk); end
      end
    end
    go_idle;
  endtask

  // per-lane distinct data; every word closes its own block
  task automatic test_declen(input logic [15:0] dl);
    int c0, n, k;
    longint ei, eq;
    dec_len = dl; en = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 10; j++) begin
      adc_val = (j < 5); lo_val = (j < 5);
      if (j < 5) set_lanes(j*7 - 10, 3, 300, -50, -(j+2), 1);
      tick; n = cyc - c0; k = n - 3;
      n_cmp++; if (iq_val !== (k >= 0 && k < 5)) begin n_bad++; $display("FAIL declen%0d_iqval n=%0d got %b", dl, n, iq_val); end
      if (k >= 0 && k < 5) begin
        ei = dot(k*7 - 10, 3, 300, -50);
        eq = dot(k*7 - 10, 3, -(k+2), 1);
        n_cmp++; if (longint'(i_out) !== ei) begin n_bad++; $display("FAIL declen%0d_i k=%0d got %0d want %0d", dl, k, i_out, ei); end
        n_cmp++; if (longint'(q_out) !== eq) begin n_bad++; $display("FAIL declen%0d_q k=%0d got %0d want %0d", dl, k, q_out, eq); end
        n_cmp++; if (blk_cnt !== 32'(exp_blk + k + 1)) begin n_bad++; $display("FAIL declen%0d_blk got %0d want %0d", dl, blk_cnt, exp_blk + k + 1); end
        last_i = ei; last_q = eq;
      end
    end
    exp_blk += 5;
    go_idle;
  endtask

  // dec_len drops to 2 mid-block: first block stays 4 words, next is 2, no gap
  task automatic test_back_to_back;
    int c0, n;
    dec_len = 16'd4; en = 1'b1; set_lanes(100, 0, 1000, 0, 0, 0);
    c0 = cyc;
    for (int j = 0; j < 12; j++) begin
      adc_val = (j < 6); lo_val = (j < 6);
      if (j == 1) dec_len = 16'd2;
      tick; n = cyc - c0;
      n_cmp++; if (iq_val !== (n == 6 || n == 8)) begin n_bad++; $display("FAIL b2b_iqval n=%0d got %b", n, iq_val); end
      if (n == 6) begin
        n_cmp++; if (i_out !== 52'sd3200000) begin n_bad++; $display("FAIL b2b_i1 got %0d want 3200000", i_out); end
      end
      if (n == 8) begin
        n_cmp++; if (i_out !== 52'sd1600000) begin n_bad++; $display("FAIL b2b_i2 got %0d want 1600000", i_out); end
        n_cmp++; if (blk_cnt !== 32'(exp_blk + 2)) begin n_bad++; $display("FAIL b2b_blk got %0d want %0d", blk_cnt, exp_blk + 2); end
      end
    end
    exp_blk += 2; last_i = 1600000; last_q = 0;
    dec_len = 16'd4;
    go_idle;
  endtask

  task automatic test_abort;
    int c0, n;
    dec_len = 16'd4; en = 1'b1; adc_val = 1'b1; lo_val = 1'b1;
    set_lanes(100, 0, 1000, 0, 0, 0);
    repeat (2) tick;
    en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick;
      n_cmp++; if (iq_val !== 1'b0) begin n_bad++; $display("FAIL abort_iqval j=%0d got %b want 0", j, iq_val); end
    end
    n_cmp++; if (longint'(i_out) !== last_i) begin n_bad++; $display("FAIL abort_hold_i got %0d want %0d", i_out, last_i); end
    n_cmp++; if (blk_cnt !== 32'(exp_blk)) begin n_bad++; $display("FAIL abort_blk got %0d want %0d", blk_cnt, exp_blk); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    en = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 10; j++) begin
      adc_val = (j < 4); lo_val = (j < 4);
      tick; n = cyc - c0;
      n_cmp++; if (iq_val !== (n == 6)) begin n_bad++; $display("FAIL abort2_iqval n=%0d got %b", n, iq_val); end
      if (n == 6) begin
        n_cmp++; if (i_out !== 52'sd3200000) begin n_bad++; $display("FAIL abort2_i got %0d want 3200000", i_out); end
      end
    end
    exp_blk++;
    go_idle;
  endtask

  task automatic test_reset_mid;
    int c0, n;
    dec_len = 16'd4; en = 1'b1; adc_val = 1'b1; lo_val = 1'b1;
    set_lanes(100, 0, 1000, 0, 0, 0);
    repeat (2) tick;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (i_out !== 52'sd0)  begin n_bad++; $display("FAIL rstmid_i got %0d want 0", i_out); end
    n_cmp++; if (blk_cnt !== 32'd0) begin n_bad++; $display("FAIL rstmid_blk got %0d want 0", blk_cnt); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    exp_blk = 0;
    repeat (2) tick;
    rst_n = 1'b1; adc_val = 1'b0; lo_val = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick;
      n_cmp++; if (iq_val !== 1'b0) begin n_bad++; $display("FAIL rstmid_spur j=%0d got %b want 0", j, iq_val); end
    end
    c0 = cyc;
    for (int j = 0; j < 10; j++) begin
      adc_val = (j < 4); lo_val = (j < 4);
      tick; n = cyc - c0;
      n_cmp++; if (iq_val !== (n == 6)) begin n_bad++; $display("FAIL rstmid2_iqval n=%0d got %b", n, iq_val); end
      if (n == 6) begin
        n_cmp++; if (i_out !== 52'sd3200000) begin n_bad++; $display("FAIL rstmid2_i got %0d want 3200000", i_out); end
        n_cmp++; if (blk_cnt !== 32'd1) begin n_bad++; $display("FAIL rstmid2_blk got %0d want 1", blk_cnt); end
      end
    end
    exp_blk = 1;
    go_idle;
  endtask

  task automatic test_fullscale;
    int c0, n;
    longint p, ei, eq;
    p  = 32768;
    ei = 8 * p * p * 65535;
    eq = -8 * p * 32767 * 65535;
    dec_len = 16'hFFFF; en = 1'b1; set_lanes(-32768, 0, -32768, 0, 32767, 0);
    c0 = cyc;
    for (int j = 0; j < 65540; j++) begin
      adc_val = (j < 65535); lo_val = (j < 65535);
      tick; n = cyc - c0;
      n_cmp++; if (iq_val !== (n == 65537)) begin n_bad++; $display("FAIL full_iqval n=%0d got %b", n, iq_val); end
      if (n == 65537) begin
        n_cmp++; if (longint'(i_out) !== ei) begin n_bad++; $display("FAIL full_i got %0d want %0d", i_out, ei); end
        n_cmp++; if (longint'(q_out) !== eq) begin n_bad++; $display("FAIL full_q got %0d want %0d", q_out, eq); end
      end
    end
    go_idle;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bubbles;
    test_declen(16'd0);
    test_declen(16'd1);
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_fullscale;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
